regfile_read_arbiter: RTL and testbench

Shares the single 32-entry register-file read port (a 32:1 read mux driven by a 5-bit select) between up to REQS requesters. Round-robin arbitration on a valid/ready request handshake, registered select into the mux, registered response. Write-to-read bypass and hard-wired zero register. Sits between the decode/operand-fetch requesters and the register-file read mux.

---
 rtl/regfile_read_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_read_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: round-robin sharing of the single register-file read port,
// with a registered mux select, write-to-read bypass and an optional hard-wired zero register.
`default_nettype none

module regfile_read_arbiter #(
  parameter int N          = 64,
  parameter int REQS       = 4,
  parameter int ZERO_REG31 = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REQS-1:0]   req_valid_i,
  input  logic [5*REQS-1:0] req_addr_i,
  output logic [REQS-1:0]   req_ready_o,
  input  logic              hold_i,
  output logic [4:0]        rf_sel_o,
  input  logic [N-1:0]      rf_data_i,
  input  logic              wr_en_i,
  input  logic [4:0]        wr_addr_i,
  input  logic [N-1:0]      wr_data_i,
  output logic [REQS-1:0]   rsp_valid_o,
  output logic [N-1:0]      rsp_data_o
);

  localparam int PW = (REQS > 1) ? $clog2(REQS) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [4:0]      rf_sel_q, rf_sel_d;
  logic [REQS-1:0] own_q, own_d;
  logic            v1_q, v1_d;
  logic [REQS-1:0] rsp_valid_q, rsp_valid_d;
  logic [N-1:0]    rsp_data_q, rsp_data_d;

  logic [REQS-1:0] grant_w;
  logic [PW-1:0]   gidx_w;
  logic [PW-1:0]   idx_w;
  logic            found_w;
  logic [4:0]      gaddr_w;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_w = '0;
    gidx_w  = ptr_q;
    idx_w   = '0;
    found_w = 1'b0;
    if (!rst_i && !hold_i) begin
      for (int k = 1; k <= REQS; k++) begin
        idx_w = PW'((int'(ptr_q) + k) % REQS);
        if (!found_w && req_valid_i[idx_w]) begin
          found_w         = 1'b1;
          grant_w[idx_w]  = 1'b1;
          gidx_w          = idx_w;
        end
      end
    end
  end

  assign gaddr_w = req_addr_i[int'(gidx_w)*5 +: 5];

  always_comb begin
    ptr_d       = ptr_q;
    rf_sel_d    = rf_sel_q;
    own_d       = own_q;
    v1_d        = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (found_w) begin
      ptr_d    = gidx_w;
      rf_sel_d = gaddr_w;
      own_d    = grant_w;
      v1_d     = 1'b1;
    end
    // Zero register beats bypass, bypass beats the (stale) mux output.
    if (v1_q) begin
      rsp_valid_d = own_q;
      if ((ZERO_REG31 != 0) && (rf_sel_q == 5'd31))
        rsp_data_d = '0;
      else if (wr_en_i && (wr_addr_i == rf_sel_q))
        rsp_data_d = wr_data_i;
      else
        rsp_data_d = rf_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= PW'(REQS - 1);
      rf_sel_q    <= '0;
      own_q       <= '0;
      v1_q        <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rf_sel_q    <= rf_sel_d;
      own_q       <= own_d;
      v1_q        <= v1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready_o = grant_w;
  assign rf_sel_o    = rf_sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter: directed vectors against a behavioural register file.
`default_nettype none

module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [3:0]  req_ready;
  logic        hold;
  logic [4:0]  rf_sel;
  logic [63:0] rf_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [3:0]  rsp_valid;
  logic [63:0] rsp_data;

  logic [63:0] regs [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) regs[wr_addr] <= wr_data;
  assign rf_data = regs[rf_sel];

  regfile_read_arbiter #(.N(64), .REQS(4), .ZERO_REG31(1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_ready_o (req_ready),
    .hold_i      (hold),
    .rf_sel_o    (rf_sel),
    .rf_data_i   (rf_data),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data)
  );

  function automatic logic [63:0] exp_reg(input int i);
    if (i == 5) return 64'h1234;
    return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h1111);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; checks run 1ns later, clear of the rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_addr(input int i, input logic [4:0] a);
    req_addr[5*i +: 5] = a;
  endtask

  int g;

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; hold = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Load the register file through the write port while in reset.
    for (int i = 0; i < 32; i++) begin
      step(); wr_en = 1'b1; wr_addr = 5'(i); wr_data = exp_reg(i);
    end
    step(); wr_en = 1'b0;
    req_valid = 4'b1111; #1;
    chk("ready_in_reset", 64'(req_ready), 64'h0);
    chk("rst_rf_sel", 64'(rf_sel), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_data", rsp_data, 64'h0);
    step(); req_valid = '0; rst = 1'b0;

    // Single request: requester 0, address 5.
    step(); req_valid = 4'b0001; set_addr(0, 5'd5); #1;
    chk("single_ready", 64'(req_ready), 64'h1);
    step(); req_valid = '0; #1;
    chk("single_rf_sel", 64'(rf_sel), 64'd5);
    chk("single_no_rsp_yet", 64'(rsp_valid), 64'h0);
    step(); #1;
    chk("single_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("single_rsp_data", rsp_data, 64'h1234);
    step(); #1;
    chk("single_rsp_one_cycle", 64'(rsp_valid), 64'h0);

    // Round robin from reset with all four requesters pending.
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) set_addr(i, 5'(10 + i));
    for (int c = 0; c < 10; c++) begin
      step(); req_valid = (c < 8) ? 4'b1111 : 4'b0000; #1;
      chk($sformatf("rr_ready_c%0d", c), 64'(req_ready), (c < 8) ? 64'(1 << (c % 4)) : 64'h0);
      if (c >= 1 && c <= 8)
        chk($sformatf("rr_sel_c%0d", c), 64'(rf_sel), 64'(10 + (c - 1) % 4));
      if (c >= 2) begin
        g = (c - 2) % 4;
        chk($sformatf("rr_rsp_valid_c%0d", c), 64'(rsp_valid), 64'(1 << g));
        chk($sformatf("rr_rsp_data_c%0d", c), rsp_data, exp_reg(10 + g));
      end else begin
        chk($sformatf("rr_rsp_idle_c%0d", c), 64'(rsp_valid), 64'h0);
      end
    end

    // Bypass: write to r7 lands at the same edge requester 2's read completes.
    step(); req_valid = 4'b0100; set_addr(2, 5'd7); #1;
    chk("byp_ready", 64'(req_ready), 64'h4);
    step(); req_valid = '0; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hBEEF; #1;
    chk("byp_rf_sel", 64'(rf_sel), 64'd7);
    step(); wr_en = 1'b0; #1;
    chk("byp_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("byp_rsp_data", rsp_data, 64'hBEEF);

    // Zero register: r31 holds 0xFFFF and is written again at the stage-2 edge.
    step(); wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF;
    step(); wr_en = 1'b0; req_valid = 4'b0010; set_addr(1, 5'd31); #1;
    chk("zero_ready", 64'(req_ready), 64'h2);
    step(); req_valid = '0; wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h5555; #1;
    chk("zero_rf_sel", 64'(rf_sel), 64'd31);
    chk("zero_rf_data_nonzero", rf_data, 64'hFFFF);
    step(); wr_en = 1'b0; #1;
    chk("zero_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("zero_rsp_data", rsp_data, 64'h0);

    // Hold: park ptr at 0, then hold off requesters 1 and 3 for three cycles.
    step(); req_valid = 4'b0001; #1;
    chk("hold_pre_ready", 64'(req_ready), 64'h1);
    step(); req_valid = '0;
    step();
    set_addr(1, 5'd3); set_addr(3, 5'd9);
    for (int h = 0; h < 3; h++) begin
      step(); req_valid = 4'b1010; hold = 1'b1; #1;
      chk($sformatf("hold_ready_h%0d", h), 64'(req_ready), 64'h0);
      chk($sformatf("hold_rsp_h%0d", h), 64'(rsp_valid), 64'h0);
    end
    step(); hold = 1'b0; #1;
    chk("hold_rel_ready1", 64'(req_ready), 64'h2);
    step(); req_valid = 4'b1000; #1;
    chk("hold_rel_ready3", 64'(req_ready), 64'h8);
    chk("hold_rel_sel1", 64'(rf_sel), 64'd3);
    step(); req_valid = '0; #1;
    chk("hold_rsp1_valid", 64'(rsp_valid), 64'h2);
    chk("hold_rsp1_data", rsp_data, exp_reg(3));
    step(); #1;
    chk("hold_rsp3_valid", 64'(rsp_valid), 64'h8);
    chk("hold_rsp3_data", rsp_data, exp_reg(9));

    // Reset one edge after a grant discards the read and restores ptr.
    set_addr(0, 5'd12);
    step(); req_valid = 4'b0100; #1;
    chk("mid_rst_grant", 64'(req_ready), 64'h4);
    step(); rst = 1'b1; req_valid = 4'b1111; #1;
    chk("mid_rst_ready_blocked", 64'(req_ready), 64'h0);
    step(); rst = 1'b0; #1;
    chk("mid_rst_no_rsp", 64'(rsp_valid), 64'h0);
    chk("mid_rst_rf_sel", 64'(rf_sel), 64'h0);
    chk("mid_rst_ptr_grant0", 64'(req_ready), 64'h1);
    step(); req_valid = '0; #1;
    chk("mid_rst_still_no_rsp", 64'(rsp_valid), 64'h0);
    chk("mid_rst_sel_after", 64'(rf_sel), 64'd12);
    step(); #1;
    chk("mid_rst_rsp0_valid", 64'(rsp_valid), 64'h1);
    chk("mid_rst_rsp0_data", rsp_data, exp_reg(12));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
